mux8_rr_sched: RTL and testbench
================================

Name: mux8_rr_sched

Overview:
- Round-robin scheduler that shares the 8:1 bit mux between eight requesters.
- Arbitrates the req vector, drives the one-hot grant and the 3-bit mux select, and registers the selected data bit.
- Bounded hold time gives fairness. Sits directly in front of the 8:1 mux datapath; sel feeds the mux select.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation when another requester is waiting (legal range 1..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  8  request vector; bit k = requester k (mux input ik).
- din  in  8  mux data inputs; din[k] corresponds to mux input ik.
- gnt  out 8  one-hot grant, registered; all-zero when idle.
- sel  out 3  mux select, registered; index of granted requester.
- o    out 1  registered mux output: din[sel] of the previous cycle while granted, else 0.
- busy out 1  high while any grant is active.

Behaviour:
- Reset: synchronous, active-high, sampled on rising clk.
  - On reset: gnt=0, sel=0, o=0, busy=0, hold counter=0, last-grant pointer=7 (first priority goes to requester 0).
  - Reset mid-grant drops gnt in the same edge; no partial state survives.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, remain in IDLE.
  - Else search indices last+1, last+2, ... (mod 8, wrap 7->0) for the first set req bit k.
  - Next cycle: gnt=1<<k, sel=k, busy=1, hold=1, last=k, go to GRANT.
  - req-to-gnt latency is 1 cycle.
- GRANT, evaluated each edge with current owner c=sel:
  - Release: req[c]==0.
    - If any other req is set, grant the next requester after c in round-robin order on this same edge (no idle bubble); hold=1.
    - Else gnt=0, busy=0, go to IDLE.
  - Forced rotation: req[c]==1, hold==MAX_HOLD, and any req[j]==1 for j!=c: grant the next requester after c; hold=1.
  - Otherwise keep the grant; hold increments and saturates at MAX_HOLD.
  - A lone requester is never forced off.
- Every new grant updates last to the new owner.
- Requests arriving mid-grant wait their round-robin turn.
- Simultaneous requests resolve strictly by distance from last, never by fixed index priority.
- Output o:
  - Each edge: o <= (gnt!=0) ? din[sel] : 0, using the current registered sel.
  - o therefore lags a grant change by 1 cycle.
- gnt is always zero or one-hot. sel equals the index of the set gnt bit whenever busy==1; sel holds its last value when idle.

Optional Feature:
- Macro: MUX8_RR_SCHED_LOCK_EN.
- Defined: adds input port lock (1 bit).
  - While lock==1 and busy==1, forced rotation is suppressed; the current owner keeps the grant until req[c] drops.
  - hold still counts and saturates.
  - lock has no effect in IDLE.
- Not defined: no lock port; forced rotation always applies as above.

Test Plan:
- Reset, then req=8'h01, din=8'h0F -> next cycle gnt=8'h01, sel=0, busy=1; following cycle o=1. Drop req -> next cycle gnt=0, busy=0, then o=0.
- req=8'h24 held, din=8'h20, MAX_HOLD=4 -> grant sequence:
  - gnt=8'h04 for 4 cycles (o=0), then gnt=8'h20 for 4 cycles (o=1), then gnt=8'h04, repeating with no idle cycles.
- req=8'h81 from reset -> gnt=8'h01 first.
  - Drop req[0] -> gnt=8'h80 on the next edge.
  - Re-raise req[0], drop req[7] -> gnt=8'h01, confirming 7->0 wrap.
- Lone req=8'h10 held 20 cycles -> gnt stays 8'h10 throughout; hold saturates; no rotation.
- Assert rst during gnt=8'h08 -> next edge gnt=0, sel=0, o=0, busy=0.
  - With req=8'hFF after reset release, the first grant is 8'h01.
- With MUX8_RR_SCHED_LOCK_EN defined: req=8'h03, lock=1 -> gnt=8'h01 persists beyond MAX_HOLD.
  - Deassert lock -> rotation to 8'h02 on the next edge.

Source files
------------

// File: rtl/mux8_rr_sched_if.sv
// Bus between the eight requesters and the round-robin mux scheduler.
// The requester side drives req/din and, when MUX8_RR_SCHED_LOCK_EN is
// defined, lock. The scheduler side returns the grant, the mux select,
// the registered mux output and busy.
interface mux8_rr_sched_if;
   logic [7:0] req;
   logic [7:0] din;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       o;
   logic       busy;
`ifdef MUX8_RR_SCHED_LOCK_EN
   logic       lock;

   modport master (output req, din, lock, input gnt, sel, o, busy);
   modport slave  (input req, din, lock, output gnt, sel, o, busy);
`else
   modport master (output req, din, input gnt, sel, o, busy);
   modport slave  (input req, din, output gnt, sel, o, busy);
`endif
endinterface

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler for a shared 8:1 bit mux.
// The grant is one-hot and registered. sel is the index of the owner.
// o registers din[sel] while a grant is active.
// The owner is forced off after MAX_HOLD cycles, but only when another
// requester is waiting.
// Optional feature: define MUX8_RR_SCHED_LOCK_EN to add a lock input.
// While lock is high, forced rotation is suppressed.
module mux8_rr_sched #(
   parameter int unsigned MAX_HOLD = 4   // legal range 1..15
) (
   input logic            clk,
   input logic            rst,
   mux8_rr_sched_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_e;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   // Returns the first set bit of r, searching base+1, base+2, ... mod 8.
   // The search ends at base itself.
   function automatic pick_t rr_pick(input logic [7:0] r, input logic [2:0] base);
      pick_t      p;
      logic [2:0] k;
      p = '0;
      for (int i = 1; i <= 8; i++) begin
         k = base + 3'(i);
         if (!p.found && r[k]) begin
            p.found = 1'b1;
            p.idx   = k;
         end
      end
      return p;
   endfunction

   state_e     state_q, state_d;
   logic [7:0] gnt_q,   gnt_d;
   logic [2:0] sel_q,   sel_d;
   logic       o_q,     o_d;
   logic       busy_q,  busy_d;
   logic [3:0] hold_q,  hold_d;
   logic [2:0] last_q,  last_d;

   logic       lock_active;
   logic [7:0] others;
   pick_t      pick;

`ifdef MUX8_RR_SCHED_LOCK_EN
   // lock only matters while a grant is held; IDLE never looks at it.
   assign lock_active = bus.lock;
`else
   assign lock_active = 1'b0;
`endif

   // Requests from everyone except the current owner.
   assign others = bus.req & ~(8'b1 << sel_q);

   // Arbitration: next grant, select, hold count and round-robin pointer.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave a value unassigned and infer a latch.
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      hold_d  = hold_q;
      last_d  = last_q;
      pick    = '0;

      unique case (state_q)
         IDLE: begin
            pick = rr_pick(bus.req, last_q);
            if (pick.found) begin
               state_d = GRANT;
               gnt_d   = 8'b1 << pick.idx;
               sel_d   = pick.idx;
               busy_d  = 1'b1;
               hold_d  = 4'd1;
               last_d  = pick.idx;
            end
         end

         GRANT: begin
            pick = rr_pick(others, sel_q);
            if (!bus.req[sel_q]) begin
               // The owner released. Hand over on this edge if anyone waits.
               if (pick.found) begin
                  gnt_d  = 8'b1 << pick.idx;
                  sel_d  = pick.idx;
                  hold_d = 4'd1;
                  last_d = pick.idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
                  hold_d  = '0;
               end
            end else if (hold_q == MAX_HOLD_C && pick.found && !lock_active) begin
               // The owner used its full share and someone else waits.
               gnt_d  = 8'b1 << pick.idx;
               sel_d  = pick.idx;
               hold_d = 4'd1;
               last_d = pick.idx;
            end else if (hold_q != MAX_HOLD_C) begin
               hold_d = hold_q + 4'd1;
            end
         end

         default: state_d = IDLE;
      endcase

      // o follows the mux using the grant and select that are registered now.
      o_d = (gnt_q != '0) ? bus.din[sel_q] : 1'b0;
   end

   // State registers; a synchronous reset clears every register on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // registers update together from values taken before the edge.
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         o_q     <= 1'b0;
         busy_q  <= 1'b0;
         hold_q  <= '0;
         last_q  <= 3'd7;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         o_q     <= o_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.sel  = sel_q;
   assign bus.o    = o_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched with MAX_HOLD = 4.
// Inputs change 1 ns after a rising edge.
// Outputs are sampled at that same point, after the edge has settled.
module tb_mux8_rr_sched;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   mux8_rr_sched_if bus ();

   mux8_rr_sched #(.MAX_HOLD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      bus.req  = '0;
      bus.din  = '0;
`ifdef MUX8_RR_SCHED_LOCK_EN
      bus.lock = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (bus.gnt !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_gnt got %h want 00", bus.gnt);
      end
      vectors++;
      if (bus.sel !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_sel got %0d want 0", bus.sel);
      end
      vectors++;
      if (bus.o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_o got %b want 0", bus.o);
      end
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy got %b want 0", bus.busy);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.req = 8'h01;
      bus.din = 8'h0F;
      tick();
      vectors++;
      if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_grant got gnt=%h sel=%0d busy=%b want 01/0/1", bus.gnt, bus.sel, bus.busy);
      end
      vectors++;
      if (bus.o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_o_lag got %b want 0", bus.o);
      end
      tick();
      vectors++;
      if (bus.o !== 1'b1) begin
         miscompares++;
         $display("FAIL single_o got %b want 1", bus.o);
      end
      bus.req = 8'h00;
      tick();
      vectors++;
      if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_release got gnt=%h busy=%b want 00/0", bus.gnt, bus.busy);
      end
      tick();
      vectors++;
      if (bus.o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_o_idle got %b want 0", bus.o);
      end
   endtask

   task automatic test_rotation();
      logic [7:0] exp_g;
      logic [7:0] prev_g;
      logic       exp_o;
      do_reset();
      bus.req = 8'h24;
      bus.din = 8'h20;
      prev_g  = 8'h00;
      for (int t = 0; t < 12; t++) begin
         tick();
         exp_g = ((t % 8) < 4) ? 8'h04 : 8'h20;
         exp_o = (prev_g == 8'h20);
         vectors++;
         if (bus.gnt !== exp_g || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rotation_gnt cycle %0d got gnt=%h busy=%b want %h/1", t, bus.gnt, bus.busy, exp_g);
         end
         vectors++;
         if (bus.o !== exp_o) begin
            miscompares++;
            $display("FAIL rotation_o cycle %0d got %b want %b", t, bus.o, exp_o);
         end
         prev_g = exp_g;
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.req = 8'h81;
      tick();
      vectors++;
      if (bus.gnt !== 8'h01) begin
         miscompares++;
         $display("FAIL wrap_first got %h want 01", bus.gnt);
      end
      bus.req = 8'h80;
      tick();
      vectors++;
      if (bus.gnt !== 8'h80 || bus.sel !== 3'd7) begin
         miscompares++;
         $display("FAIL wrap_to7 got gnt=%h sel=%0d want 80/7", bus.gnt, bus.sel);
      end
      bus.req = 8'h01;
      tick();
      vectors++;
      if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_to0 got gnt=%h sel=%0d busy=%b want 01/0/1", bus.gnt, bus.sel, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      // The owner is 2 and requests 0 and 3 are waiting: distance picks 3.
      do_reset();
      bus.req = 8'h04;
      tick();
      vectors++;
      if (bus.gnt !== 8'h04) begin
         miscompares++;
         $display("FAIL b2b_first got %h want 04", bus.gnt);
      end
      bus.req = 8'h09;
      tick();
      vectors++;
      if (bus.gnt !== 8'h08 || bus.sel !== 3'd3 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_distance got gnt=%h sel=%0d busy=%b want 08/3/1", bus.gnt, bus.sel, bus.busy);
      end
      bus.req = 8'h01;
      tick();
      vectors++;
      if (bus.gnt !== 8'h01 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_handoff got gnt=%h busy=%b want 01/1", bus.gnt, bus.busy);
      end
   endtask

   task automatic test_lone();
      int bad;
      do_reset();
      bus.req = 8'h10;
      bad     = 0;
      for (int t = 0; t < 20; t++) begin
         tick();
         vectors++;
         if (bus.gnt !== 8'h10 || bus.sel !== 3'd4) begin
            miscompares++;
            bad++;
            if (bad < 4)
               $display("FAIL lone cycle %0d got gnt=%h sel=%0d want 10/4", t, bus.gnt, bus.sel);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req = 8'h08;
      bus.din = 8'hFF;
      tick();
      tick();
      vectors++;
      if (bus.gnt !== 8'h08 || bus.o !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_pre got gnt=%h o=%b want 08/1", bus.gnt, bus.o);
      end
      rst = 1'b1;
      tick();
      vectors++;
      if (bus.gnt !== 8'h00 || bus.sel !== 3'd0 || bus.o !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst got gnt=%h sel=%0d o=%b busy=%b want 00/0/0/0", bus.gnt, bus.sel, bus.o, bus.busy);
      end
      rst     = 1'b0;
      bus.req = 8'hFF;
      tick();
      vectors++;
      if (bus.gnt !== 8'h01 || bus.sel !== 3'd0) begin
         miscompares++;
         $display("FAIL midrst_after got gnt=%h sel=%0d want 01/0", bus.gnt, bus.sel);
      end
   endtask

`ifdef MUX8_RR_SCHED_LOCK_EN
   task automatic test_lock();
      do_reset();
      bus.lock = 1'b1;
      bus.req  = 8'h03;
      for (int t = 0; t < 8; t++) begin
         tick();
         vectors++;
         if (bus.gnt !== 8'h01) begin
            miscompares++;
            $display("FAIL lock_hold cycle %0d got %h want 01", t, bus.gnt);
         end
      end
      bus.lock = 1'b0;
      tick();
      vectors++;
      if (bus.gnt !== 8'h02 || bus.sel !== 3'd1) begin
         miscompares++;
         $display("FAIL lock_release got gnt=%h sel=%0d want 02/1", bus.gnt, bus.sel);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_back_to_back();
      test_lone();
      test_reset_mid();
`ifdef MUX8_RR_SCHED_LOCK_EN
      test_lock();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
